// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the tinyCPU register file with load scoreboard.
package regfile_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned AW_DEF   = 3;
  localparam int unsigned ZERO_REG = 0;

  // Outstanding-load count after one cycle: at most one set and one clear per edge.
  function automatic int unsigned pend_cnt_next(input int unsigned cnt,
                                                input logic        set,
                                                input logic        clr);
    return cnt + {31'b0, set} - {31'b0, clr};
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, optional write-back bypass (M over E), ready flag.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dstM,
  input  logic [DW-1:0] M,
  input  logic [AW-1:0] dstE,
  input  logic [DW-1:0] E,
  input  logic [DW-1:0] rf_val,
  input  logic          pend,
  output logic [DW-1:0] data_c,
  output logic          rdy_c
);

  // A load write-back on dstM satisfies a pending operand in the same cycle when bypassing.
  always_comb begin
    data_c = rf_val;
    rdy_c  = !pend;
    if (src == AW'(ZERO_REG)) begin
      data_c = '0;
    end else if (BYPASS != 0) begin
      if (src == dstM) begin
        data_c = M;
        rdy_c  = 1'b1;
      end else if (src == dstE) begin
        data_c = E;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with per-register pending-load scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] srcA,
  input  logic [AW-1:0] srcB,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          A_rdy,
  output logic          B_rdy,
  input  logic [AW-1:0] dstM,
  input  logic [DW-1:0] M,
  input  logic [AW-1:0] dstE,
  input  logic [DW-1:0] E,
  input  logic [AW-1:0] claim,
  output logic          claim_busy,
  output logic [AW:0]   pend_cnt
);

  localparam int unsigned NREG = 2**AW;

  logic [DW-1:0]   rf_q [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic            set_c;
  logic            clr_c;

  // Scoreboard update: the write-back clear lands before the claim set.
  always_comb begin
    clr_c      = (dstM != AW'(ZERO_REG)) && pend_q[dstM];
    claim_busy = pend_q[claim] &&
                 !((BYPASS != 0) && (dstM == claim) && (dstM != AW'(ZERO_REG)));
    set_c      = (claim != AW'(ZERO_REG)) && !claim_busy;
    pend_d     = pend_q;
    if (clr_c) pend_d[dstM] = 1'b0;
    if (set_c) pend_d[claim] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      pend_cnt <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_cnt <= (AW+1)'(pend_cnt_next(32'(pend_cnt), set_c, clr_c));
    end
  end

  // M wins over E on a shared destination; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      if (dstM != AW'(ZERO_REG)) rf_q[dstM] <= M;
      if ((dstE != AW'(ZERO_REG)) && (dstE != dstM)) rf_q[dstE] <= E;
    end
  end

  regfile_rdport #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd_a (
    .src    (srcA),
    .dstM   (dstM),
    .M      (M),
    .dstE   (dstE),
    .E      (E),
    .rf_val (rf_q[srcA]),
    .pend   (pend_q[srcA]),
    .data_c (A),
    .rdy_c  (A_rdy)
  );

  regfile_rdport #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd_b (
    .src    (srcB),
    .dstM   (dstM),
    .M      (M),
    .dstE   (dstE),
    .E      (E),
    .rf_val (rf_q[srcB]),
    .pend   (pend_q[srcB]),
    .data_c (B),
    .rdy_c  (B_rdy)
  );

endmodule
